nibble_add_sequencer: RTL
=========================

// Module: nibble_add_sequencer
// PURPOSE
//  Controller that computes wide additions by time-multiplexing one external
//  4-bit ripple adder slice (a/b/cin -> Sum/Cout), one nibble per cycle, LSB first.
//  Accepts operands over a valid/ready request port and returns sum plus carry-out
//  over a valid/ready response port. Sits between a requesting block and the
//  shared combinational adder.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles; W = 4*NIBBLES bits; legal range 1..16
// PORTS
//  clk         in   1     clock; all state updates on rising edge
//  rst         in   1     asynchronous reset, active-high
//  req_valid   in   1     request operands valid
//  req_ready   out  1     sequencer can accept a request
//  req_a       in   W     operand A
//  req_b       in   W     operand B
//  req_cin     in   1     carry-in for the least significant nibble
//  resp_valid  out  1     result valid
//  resp_ready  in   1     consumer takes result
//  resp_sum    out  W     A + B + cin, modulo 2^W
//  resp_cout   out  1     carry out of the most significant nibble
//  busy        out  1     high whenever state != IDLE
//  add_a       out  4     nibble of A driven to the adder slice
//  add_b       out  4     nibble of B driven to the adder slice
//  add_cin     out  1     carry driven to the adder slice
//  add_sum     in   4     adder slice Sum (combinational response, same cycle)
//  add_cout    in   1     adder slice Cout (combinational response, same cycle)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, idx=0, carry=0, operand and result regs=0.
//   Outputs: req_ready=1 once rst falls, resp_valid=0, resp_sum=0, resp_cout=0,
//   busy=0, add_a=0, add_b=0, add_cin=0. rst mid-RUN or mid-DONE discards the op.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: req_ready=1. On edge with req_valid=1, latch req_a/req_b, carry<=req_cin,
//   idx<=0, go RUN. Accepted edge is T0.
//  RUN: req_ready=0. add_a=A[4*idx+:4], add_b=B[4*idx+:4], add_cin=carry.
//   Each edge: R[4*idx+:4]<=add_sum, carry<=add_cout, idx<=idx+1.
//   When idx==NIBBLES-1 at the edge: go DONE, resp_cout<=add_cout, idx<=0.
//  DONE: resp_valid=1; resp_sum=R, resp_cout stable and unchanged until handshake.
//   Edge with resp_ready=1: go IDLE; resp_valid drops next cycle.
//   req_ready=0 in DONE; no new request accepted until back in IDLE.
//  Latency: RUN lasts exactly NIBBLES cycles; resp_valid first high in the cycle
//   after edge T0+NIBBLES. Throughput with resp_ready=1: one op per NIBBLES+2 cycles.
//  add_a/add_b/add_cin are 0 in IDLE and DONE; adder outputs ignored outside RUN.
//  NIBBLES=1: RUN lasts one cycle, idx stays 0, still enters DONE.
//  Operands on req_* may change after acceptance with no effect on the result.
//  resp_sum/resp_cout hold the last result in IDLE until the next DONE overwrites.
//  idx width = max(1,clog2(NIBBLES)); no wrap beyond NIBBLES-1 is reachable.
// TESTING (NIBBLES=4, bench models adder slice as add_sum/add_cout = a+b+cin)
//  1. A=0000,B=0000,cin=0 -> resp_sum=0000,resp_cout=0; resp_valid 5 cycles after T0.
//  2. A=00FF,B=0001,cin=0 -> resp_sum=0100,resp_cout=0 (carry across nibble 1..2).
//  3. A=FFFF,B=0001,cin=0 -> resp_sum=0000,resp_cout=1; A=1234,B=4321,cin=1 -> 5556.
//  4. resp_ready low 3 cycles in DONE, req_valid high -> result stable, req_ready=0,
//     second request accepted only in IDLE; its result correct.
//  5. rst pulse at 2nd RUN cycle -> all outputs return to reset values immediately;
//     next request 0007+0008 -> 000F, cout=0.
//  6. Back-to-back requests, resp_ready tied 1 -> results in order, spacing 6 cycles.

Source files
------------

// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: wide add by sequencing one external 4-bit adder slice LSB nibble first
module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic                 req_cin,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [4*NIBBLES-1:0] resp_sum,
    output logic                 resp_cout,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_q, b_q, w_q, w_nx, r_q;
    logic            cout_q;
    logic            last;

    assign last       = idx == IW'(NIBBLES - 1);
    assign req_ready  = state == IDLE;
    assign resp_valid = state == DONE;
    assign busy       = state != IDLE;
    assign add_a      = state == RUN ? a_q[4*idx+:4] : 4'd0;
    assign add_b      = state == RUN ? b_q[4*idx+:4] : 4'd0;
    assign add_cin    = state == RUN ? carry : 1'b0;
    assign resp_sum   = r_q;
    assign resp_cout  = cout_q;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and working sum with the current slice result merged in
    always_comb begin
        state_nx = state;
        if (state == IDLE && req_valid)  state_nx = RUN;
        if (state == RUN && last)        state_nx = DONE;
        if (state == DONE && resp_ready) state_nx = IDLE;
        w_nx = w_q;
        w_nx[4*idx+:4] = add_sum;
    end

    // operand latch, nibble sequencing; result published only at the final nibble so it holds until then
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            w_q    <= '0;
            r_q    <= '0;
            cout_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            carry <= req_cin;
            idx   <= '0;
        end else if (state == RUN) begin
            w_q   <= w_nx;
            carry <= add_cout;
            idx   <= last ? '0 : idx + IW'(1);
            if (last) begin
                r_q    <= w_nx;
                cout_q <= add_cout;
            end
        end
    end
endmodule
